// File: rtl/fp_pow2k_pkg.sv
// fp_pow2k_pkg: shared constants, FSM state and operand class types for fp_pow2k
package fp_pow2k_pkg;
  localparam logic signed [10:0] BIAS    = 11'sd127;
  localparam logic signed [10:0] EXP_MAX = 11'sd127;
  localparam logic signed [10:0] EXP_MIN = -11'sd126;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;
  typedef enum logic [1:0] {S_IDLE, S_SQ, S_PACK} state_t;
  typedef enum logic [1:0] {C_NORM, C_ZERO, C_INF, C_NAN} cls_t;
endpackage

// File: rtl/fp_pow2k_mant_sq_norm.sv
// mant_sq_norm: one combinational squaring step of a normalised mantissa/exponent pair.
// Ports: m_i/e_i current mantissa {1,frac} and unbiased exponent; m_o/e_o next pair;
// ovf_o/unf_o flag the next exponent leaving the normal range.
// FP_POW2K_RNE_EN selects round-to-nearest-even on the discarded bits; otherwise truncate.
module mant_sq_norm
  import fp_pow2k_pkg::*;
(
  input  logic [23:0]        m_i,
  input  logic signed [10:0] e_i,
  output logic [23:0]        m_o,
  output logic signed [10:0] e_o,
  output logic               ovf_o,
  output logic               unf_o
);
  logic [47:0] p;
  logic hi;
  logic [23:0] mt;
  logic signed [10:0] et;
  assign p  = {24'b0, m_i} * {24'b0, m_i};
  assign hi = p[47];
  assign mt = hi ? p[47:24] : p[46:23];
  assign et = (e_i <<< 1) + (hi ? 11'sd1 : 11'sd0);
`ifdef FP_POW2K_RNE_EN
  logic g, s;
  logic [24:0] mr;
  assign g  = hi ? p[23] : p[22];
  assign s  = hi ? |p[22:0] : |p[21:0];
  assign mr = {1'b0, mt} + {24'b0, g & (s | mt[0])};
  // a carry out of all-ones mantissa renormalises to 1.0 with the next exponent
  assign m_o = mr[24] ? 24'h800000 : mr[23:0];
  assign e_o = et + (mr[24] ? 11'sd1 : 11'sd0);
`else
  logic unused_lo;
  assign unused_lo = ^p[22:0];
  assign m_o = mt;
  assign e_o = et;
`endif
  assign ovf_o = e_o > EXP_MAX;
  assign unf_o = e_o < EXP_MIN;
endmodule

// File: rtl/fp_pow2k.sv
// fp_pow2k: computes x^(2^k) for an IEEE754 single by k repeated squarings.
// Ports: clk, rst_n (async active-low); start/fp_in/nsq request; busy while working;
// done pulses with fp_out/over/under valid. Optional macro FP_POW2K_RNE_EN enables
// round-to-nearest-even on each squaring (in mant_sq_norm).
module fp_pow2k
  import fp_pow2k_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] fp_in,
  input  logic [4:0]  nsq,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_out,
  output logic        over,
  output logic        under
);
  state_t state_q, state_d;
  cls_t cls_q, cls_d, cls_in;
  logic sign_q, sign_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [23:0] m_q, m_d, m_n;
  logic signed [10:0] e_q, e_d, e_n;
  logic [4:0] k_q, k_d;
  logic [31:0] fp_out_q, fp_out_d, res;
  logic done_q, done_d, over_q, over_d, under_q, under_d, ovf_n, unf_n;
  logic [7:0] ef;

  mant_sq_norm u_sq (.m_i(m_q), .e_i(e_q), .m_o(m_n), .e_o(e_n), .ovf_o(ovf_n), .unf_o(unf_n));

  assign cls_in = (fp_in[30:23] == 8'hFF) ? ((fp_in[22:0] != 23'h0) ? C_NAN : C_INF) :
                  (fp_in[30:23] == 8'h00) ? C_ZERO : C_NORM;
  assign ef  = 8'(e_q + BIAS);
  assign res = ovf_q ? PINF :
               unf_q ? 32'h0 :
               (cls_q == C_NAN)  ? QNAN :
               (cls_q == C_INF)  ? {sign_q, 8'hFF, 23'h0} :
               (cls_q == C_ZERO) ? {sign_q, 31'h0} : {sign_q, ef, m_q[22:0]};

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    sign_d   = sign_q;
    m_d      = m_q;
    e_d      = e_q;
    k_d      = k_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    fp_out_d = fp_out_q;
    over_d   = over_q;
    under_d  = under_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        sign_d  = (nsq == 5'd0) ? fp_in[31] : 1'b0;
        e_d     = $signed({3'b000, fp_in[30:23]}) - BIAS;
        m_d     = {1'b1, fp_in[22:0]};
        k_d     = nsq;
        cls_d   = cls_in;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        state_d = (cls_in == C_NORM && nsq != 5'd0) ? S_SQ : S_PACK;
      end
      S_SQ: begin
        m_d   = m_n;
        e_d   = e_n;
        k_d   = k_q - 5'd1;
        ovf_d = ovf_n;
        unf_d = unf_n;
        state_d = (k_q == 5'd1 || ovf_n || unf_n) ? S_PACK : S_SQ;
      end
      S_PACK: begin
        fp_out_d = res;
        over_d   = ovf_q;
        under_d  = unf_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cls_q    <= C_NORM;
      sign_q   <= 1'b0;
      m_q      <= 24'h0;
      e_q      <= 11'sd0;
      k_q      <= 5'd0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      fp_out_q <= 32'h0;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      sign_q   <= sign_d;
      m_q      <= m_d;
      e_q      <= e_d;
      k_q      <= k_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      fp_out_q <= fp_out_d;
      over_q   <= over_d;
      under_q  <= under_d;
      done_q   <= done_d;
    end

  assign busy   = state_q != S_IDLE;
  assign done   = done_q;
  assign fp_out = fp_out_q;
  assign over   = over_q;
  assign under  = under_q;
endmodule

// File: tb/tb_fp_pow2k.sv
// tb_fp_pow2k: directed scoreboard bench for fp_pow2k
module tb_fp_pow2k;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] fp_in = 32'h0;
  logic [4:0] nsq = 5'd0;
  logic busy, done, over, under;
  logic [31:0] fp_out;

  fp_pow2k dut (.clk(clk), .rst_n(rst_n), .start(start), .fp_in(fp_in), .nsq(nsq),
                .busy(busy), .done(done), .fp_out(fp_out), .over(over), .under(under));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] o;
    logic ov;
    logic un;
    logic [7:0] lat;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic run(input logic [31:0] x, input logic [4:0] k, input logic [31:0] o,
                     input logic ov, input logic un, input int lat);
    exp_t e, g;
    int n;
    bit seen;
    e.o = o; e.ov = ov; e.un = un; e.lat = 8'(lat);
    sb.push_back(e);
    @(negedge clk);
    fp_in = x; nsq = k; start = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      seen = (done === 1'b1);
    end
    g = sb.pop_front();
    chk($sformatf("done_seen x=%h k=%0d", x, k), 32'(seen), 32'd1);
    chk($sformatf("fp_out x=%h k=%0d", x, k), fp_out, g.o);
    chk($sformatf("over x=%h k=%0d", x, k), {31'b0, over}, {31'b0, g.ov});
    chk($sformatf("under x=%h k=%0d", x, k), {31'b0, under}, {31'b0, g.un});
    chk($sformatf("latency x=%h k=%0d", x, k), 32'(n), {24'b0, g.lat});
  endtask

  initial begin
    int dn;
    logic [31:0] cap;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset flags", {30'b0, over, under}, 32'd0);
    chk("reset fp_out", fp_out, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    run(32'h3FC00000, 5'd1, 32'h40100000, 1'b0, 1'b0, 3);
    run(32'h40000000, 5'd3, 32'h43800000, 1'b0, 1'b0, 5);
    run(32'hC0000000, 5'd1, 32'h40800000, 1'b0, 1'b0, 3);
    run(32'h40000000, 5'd8, 32'h7F800000, 1'b1, 1'b0, 9);
    run(32'h3F000000, 5'd8, 32'h00000000, 1'b0, 1'b1, 9);
    run(32'hC0400000, 5'd0, 32'hC0400000, 1'b0, 1'b0, 2);
    run(32'h7FC00001, 5'd3, 32'h7FC00000, 1'b0, 1'b0, 2);
    run(32'hFFC12345, 5'd0, 32'h7FC00000, 1'b0, 1'b0, 2);
    run(32'h00000000, 5'd5, 32'h00000000, 1'b0, 1'b0, 2);
    run(32'h80000000, 5'd3, 32'h00000000, 1'b0, 1'b0, 2);
    run(32'h80000001, 5'd0, 32'h80000000, 1'b0, 1'b0, 2);
    run(32'h7F800000, 5'd2, 32'h7F800000, 1'b0, 1'b0, 2);
    run(32'hFF800000, 5'd0, 32'hFF800000, 1'b0, 1'b0, 2);
    run(32'h3FC00000, 5'd2, 32'h40A20000, 1'b0, 1'b0, 4);
    run(32'h3F800001, 5'd1, 32'h3F800002, 1'b0, 1'b0, 3);
    run(32'h5F800000, 5'd1, 32'h7F800000, 1'b1, 1'b0, 3);
    run(32'h20000000, 5'd1, 32'h00800000, 1'b0, 1'b0, 3);
    run(32'h1F800000, 5'd1, 32'h00000000, 1'b0, 1'b1, 3);
    run(32'h5F400000, 5'd1, 32'h7F100000, 1'b0, 1'b0, 3);
    @(negedge clk);
    fp_in = 32'h3F800000; nsq = 5'd20; start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy mid-op", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    chk("abort fp_out", fp_out, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1) dn++;
    end
    chk("no done after abort", 32'(dn), 32'd0);
    run(32'h40000000, 5'd1, 32'h40800000, 1'b0, 1'b0, 3);
    @(negedge clk);
    fp_in = 32'h3F800000; nsq = 5'd4; start = 1'b1;
    @(negedge clk);
    fp_in = 32'h40000000; nsq = 5'd1; start = 1'b1;
    @(negedge clk) start = 1'b0;
    dn = 0; cap = 32'hDEADBEEF;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin dn++; cap = fp_out; end
    end
    chk("dones with start while busy", 32'(dn), 32'd1);
    chk("result with start while busy", cap, 32'h3F800000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
